// File: rtl/usb_tx_pkt_ctrl_if.sv
// Handshake bundle between the TX FIFO/protocol side and the USB TX packet sequencer.
// master: FIFO/protocol/bit-timer side; slave: the sequencer.
interface usb_tx_pkt_ctrl_if #(parameter int BUF_AW = 7);
    logic              strobe;
    logic              byte_transmitted;
    logic [BUF_AW-1:0] buffer_occupancy;
    logic [3:0]        tx_packet;
    logic              get_tx_packet_data;
    logic              tx_transfer_active;
    logic              tx_error;
    logic              timer_enable;
    logic              timer_clear;
    logic              pts_load_enable;
    logic              pts_shift_enable;
    logic [2:0]        load_sel;
    logic              crc_clear;
    logic              eop;
    logic              idle;
    logic              packet_done;

    modport master (
        output strobe, byte_transmitted, buffer_occupancy, tx_packet,
        input  get_tx_packet_data, tx_transfer_active, tx_error, timer_enable, timer_clear,
               pts_load_enable, pts_shift_enable, load_sel, crc_clear, eop, idle, packet_done
    );

    modport slave (
        input  strobe, byte_transmitted, buffer_occupancy, tx_packet,
        output get_tx_packet_data, tx_transfer_active, tx_error, timer_enable, timer_clear,
               pts_load_enable, pts_shift_enable, load_sel, crc_clear, eop, idle, packet_done
    );
endinterface

// File: rtl/usb_tx_pkt_ctrl.sv
// USB full-speed TX packet sequencer: SYNC, PID, token/data payload, CRC, EOP, inter-packet gap.
// Optional macro ZLP_EN: a DATA request with an empty FIFO sends a zero-length packet instead of erroring.
module usb_tx_pkt_ctrl #(
    parameter int BUF_AW         = 7,
    parameter int MAX_DATA_BYTES = 64,
    parameter int EOP_BITS       = 2,
    parameter int IDLE_GAP       = 3
) (
    input  logic              clk,
    input  logic              rst,
    usb_tx_pkt_ctrl_if.slave  bus
);
    localparam int CNT_W = $clog2(MAX_DATA_BYTES + 1);
    localparam int EOP_W = (EOP_BITS > 1) ? $clog2(EOP_BITS) : 1;
    localparam int GAP_W = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;

    typedef enum logic [3:0] {
        S_IDLE, S_SYNC_LD, S_SYNC, S_PID_LD, S_PID, S_TOK_LD, S_TOK, S_DATA_LD,
        S_DATA, S_DATA_CHK, S_CRC_LD, S_CRC, S_EOP, S_GAP, S_ERR
    } state_t;

    typedef enum logic [1:0] {PC_DATA, PC_TOKEN, PC_HS, PC_ERR} pid_class_t;

    typedef struct packed {
        logic       get;
        logic       active;
        logic       err;
        logic       tmr_en;
        logic       tmr_clr;
        logic       load;
        logic       shift;
        logic [2:0] sel;
        logic       crc_clr;
        logic       eop;
        logic       idle;
        logic       done;
    } out_t;

    function automatic pid_class_t classify(input logic [3:0] pid);
        case (pid)
            4'b0011, 4'b1011:          classify = PC_DATA;
            4'b0001, 4'b1001, 4'b1101: classify = PC_TOKEN;
            4'b0010, 4'b1010, 4'b1110: classify = PC_HS;
            default:                   classify = PC_ERR;
        endcase
    endfunction

    // Outputs are a pure decode of the state being entered, so registering them keeps Moore timing.
    function automatic out_t decode(input state_t st, input logic idx);
        decode = '0;
        case (st)
            S_IDLE:     begin decode.idle = 1'b1; decode.tmr_clr = 1'b1; end
            S_SYNC_LD:  begin decode.load = 1'b1; decode.active = 1'b1; decode.sel = 3'd0; end
            S_PID_LD:   begin decode.load = 1'b1; decode.active = 1'b1; decode.sel = 3'd1; decode.crc_clr = 1'b1; end
            S_TOK_LD:   begin decode.load = 1'b1; decode.active = 1'b1; decode.sel = 3'd3 + {2'b00, idx}; end
            S_DATA_LD:  begin decode.load = 1'b1; decode.active = 1'b1; decode.sel = 3'd2; end
            S_CRC_LD:   begin decode.load = 1'b1; decode.active = 1'b1; decode.sel = 3'd5 + {2'b00, idx}; end
            S_SYNC, S_PID, S_TOK, S_DATA, S_CRC:
                        begin decode.shift = 1'b1; decode.tmr_en = 1'b1; decode.active = 1'b1; end
            S_DATA_CHK: begin decode.get = 1'b1; decode.active = 1'b1; end
            S_EOP:      begin decode.eop = 1'b1; decode.active = 1'b1; end
            S_GAP:      decode.idle = 1'b1;
            S_ERR:      decode.err = 1'b1;
            default:    decode = '0;
        endcase
    endfunction

    state_t            state_r, state_s;
    logic [3:0]        pid_r, pid_s;
    logic              idx_r, idx_s;
    logic              zlp_r, zlp_s;
    logic              ovf_r, ovf_s;
    logic [CNT_W-1:0]  byte_cnt_r, byte_cnt_s;
    logic [EOP_W-1:0]  eop_cnt_r, eop_cnt_s;
    logic [GAP_W-1:0]  gap_cnt_r, gap_cnt_s;
    logic              done_s;
    out_t              out_r, out_s;
    logic [BUF_AW-1:0] occ_s;
    logic              occ_nz_s;
    pid_class_t        req_class_s, pid_class_s;

    assign occ_s       = bus.buffer_occupancy;
    assign occ_nz_s    = |occ_s;
    assign req_class_s = classify(bus.tx_packet);
    assign pid_class_s = classify(pid_r);

    // Next-state and counter logic.
    always_comb begin
        state_s    = state_r;
        pid_s      = pid_r;
        idx_s      = idx_r;
        zlp_s      = zlp_r;
        ovf_s      = ovf_r;
        byte_cnt_s = byte_cnt_r;
        eop_cnt_s  = '0;
        gap_cnt_s  = '0;
        done_s     = 1'b0;
        case (state_r)
            S_IDLE: begin
                byte_cnt_s = '0;
                idx_s      = 1'b0;
                ovf_s      = 1'b0;
                zlp_s      = 1'b0;
                if (bus.tx_packet != 4'd0) begin
                    pid_s = bus.tx_packet;
                    if (req_class_s == PC_ERR) begin
                        state_s = S_ERR;
                    end else if (req_class_s == PC_DATA && !occ_nz_s) begin
`ifdef ZLP_EN
                        zlp_s   = 1'b1;
                        state_s = S_SYNC_LD;
`else
                        state_s = S_ERR;
`endif
                    end else begin
                        state_s = S_SYNC_LD;
                    end
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_SYNC_LD: state_s = S_SYNC;
            S_SYNC:    state_s = bus.byte_transmitted ? S_PID_LD : S_SYNC;
            S_PID_LD:  state_s = S_PID;
            S_PID: begin
                idx_s = 1'b0;
                if (bus.byte_transmitted) begin
                    case (pid_class_s)
                        PC_DATA:  state_s = zlp_r ? S_CRC_LD : S_DATA_LD;
                        PC_TOKEN: state_s = S_TOK_LD;
                        default:  state_s = S_EOP;
                    endcase
                end else begin
                    state_s = S_PID;
                end
            end
            S_TOK_LD:  state_s = S_TOK;
            S_TOK: begin
                if (bus.byte_transmitted) begin
                    if (idx_r == 1'b0) begin
                        idx_s   = 1'b1;
                        state_s = S_TOK_LD;
                    end else begin
                        state_s = S_EOP;
                    end
                end else begin
                    state_s = S_TOK;
                end
            end
            S_DATA_LD: begin
                if (byte_cnt_r != CNT_W'(MAX_DATA_BYTES)) begin
                    byte_cnt_s = byte_cnt_r + CNT_W'(1);
                end else begin
                    byte_cnt_s = byte_cnt_r;
                end
                state_s = S_DATA;
            end
            S_DATA:    state_s = bus.byte_transmitted ? S_DATA_CHK : S_DATA;
            S_DATA_CHK: begin
                idx_s = 1'b0;
                if (occ_nz_s && byte_cnt_r == CNT_W'(MAX_DATA_BYTES)) begin
                    ovf_s   = 1'b1;
                    state_s = S_ERR;
                end else if (occ_nz_s) begin
                    state_s = S_DATA_LD;
                end else begin
                    state_s = S_CRC_LD;
                end
            end
            S_CRC_LD:  state_s = S_CRC;
            S_CRC: begin
                if (bus.byte_transmitted) begin
                    if (idx_r == 1'b0) begin
                        idx_s   = 1'b1;
                        state_s = S_CRC_LD;
                    end else begin
                        state_s = S_EOP;
                    end
                end else begin
                    state_s = S_CRC;
                end
            end
            S_EOP: begin
                eop_cnt_s = eop_cnt_r;
                if (bus.strobe && eop_cnt_r == EOP_W'(EOP_BITS - 1)) begin
                    done_s  = 1'b1;
                    state_s = (IDLE_GAP == 0) ? S_IDLE : S_GAP;
                end else if (bus.strobe) begin
                    eop_cnt_s = eop_cnt_r + EOP_W'(1);
                end else begin
                    eop_cnt_s = eop_cnt_r;
                end
            end
            S_GAP: begin
                gap_cnt_s = gap_cnt_r + GAP_W'(1);
                if (gap_cnt_r == GAP_W'(IDLE_GAP - 1)) begin
                    state_s = S_IDLE;
                end else begin
                    state_s = S_GAP;
                end
            end
            // An overflow still closes the packet on the line; a start error never left IDLE.
            S_ERR:     state_s = ovf_r ? S_EOP : S_IDLE;
            default:   state_s = S_IDLE;
        endcase
    end

    // Output decode of the next state; packet_done marks the cycle after the final EOP strobe.
    always_comb begin
        out_s      = decode(state_s, idx_s);
        out_s.done = done_s;
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= S_IDLE;
            pid_r      <= 4'd0;
            idx_r      <= 1'b0;
            zlp_r      <= 1'b0;
            ovf_r      <= 1'b0;
            byte_cnt_r <= '0;
            eop_cnt_r  <= '0;
            gap_cnt_r  <= '0;
            out_r      <= decode(S_IDLE, 1'b0);
        end else begin
            state_r    <= state_s;
            pid_r      <= pid_s;
            idx_r      <= idx_s;
            zlp_r      <= zlp_s;
            ovf_r      <= ovf_s;
            byte_cnt_r <= byte_cnt_s;
            eop_cnt_r  <= eop_cnt_s;
            gap_cnt_r  <= gap_cnt_s;
            out_r      <= out_s;
        end
    end

    assign bus.get_tx_packet_data = out_r.get;
    assign bus.tx_transfer_active = out_r.active;
    assign bus.tx_error           = out_r.err;
    assign bus.timer_enable       = out_r.tmr_en;
    assign bus.timer_clear        = out_r.tmr_clr;
    assign bus.pts_load_enable    = out_r.load;
    assign bus.pts_shift_enable   = out_r.shift;
    assign bus.load_sel           = out_r.sel;
    assign bus.crc_clear          = out_r.crc_clr;
    assign bus.eop                = out_r.eop;
    assign bus.idle               = out_r.idle;
    assign bus.packet_done        = out_r.done;
endmodule

// File: tb/tb_usb_tx_pkt_ctrl.sv
// Directed self-checking bench for usb_tx_pkt_ctrl (MAX_DATA_BYTES=4, EOP_BITS=2, IDLE_GAP=3).
module tb_usb_tx_pkt_ctrl;
    localparam int BUF_AW = 7;
    localparam int MAXB   = 4;
    localparam int EOPB   = 2;
    localparam int GAP    = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    usb_tx_pkt_ctrl_if #(.BUF_AW(BUF_AW)) bus ();

    usb_tx_pkt_ctrl #(.BUF_AW(BUF_AW), .MAX_DATA_BYTES(MAXB), .EOP_BITS(EOPB), .IDLE_GAP(GAP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;
    int fifo_base = 0;
    int pop_base = 0;
    int pop_cnt = 0;
    int occ_int;
    bit hold_occ = 1'b0;
    int n_err = 0, n_done = 0, n_crcclr = 0, n_bt = 0, n_eop_str = 0;
    int shift_cyc = 0, div = 0;
    logic [2:0] ld_log[$];

    // FIFO model: occupancy already reflects the byte being popped this cycle.
    always @(posedge clk) if (bus.get_tx_packet_data === 1'b1) pop_cnt <= pop_cnt + 1;

    always_comb begin
        occ_int = hold_occ ? fifo_base : fifo_base - (pop_cnt - pop_base) - int'(bus.get_tx_packet_data);
        if (occ_int < 0) occ_int = 0;
    end
    assign bus.buffer_occupancy = occ_int[BUF_AW-1:0];

    // Serialiser/bit-timer responder plus event monitor.
    always @(negedge clk) begin
        if (bus.pts_load_enable === 1'b1) ld_log.push_back(bus.load_sel);
        if (bus.crc_clear === 1'b1) n_crcclr++;
        if (bus.tx_error === 1'b1) n_err++;
        if (bus.packet_done === 1'b1) n_done++;
        div = (div + 1) % 4;
        bus.strobe = (div == 0);
        if (bus.eop === 1'b1 && bus.strobe) n_eop_str++;
        if (bus.pts_shift_enable === 1'b1) begin
            shift_cyc++;
            bus.byte_transmitted = (shift_cyc == 3);
            if (bus.byte_transmitted) begin
                n_bt++;
                shift_cyc = 0;
            end
        end else begin
            shift_cyc = 0;
            bus.byte_transmitted = 1'b0;
        end
    end

    function automatic logic [31:0] log_sig(input int from);
        logic [27:0] body = '0;
        int n = 0;
        for (int i = from; i < ld_log.size(); i++) begin
            body = {body[23:0], 1'b0, ld_log[i]};
            n++;
        end
        if (n > 15) n = 15;
        return {n[3:0], body};
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [3:0] pid);
        for (int c = 0; c < 50 && bus.timer_clear !== 1'b1; c++) step(1);
        bus.tx_packet = pid;
        step(1);
        bus.tx_packet = 4'd0;
    endtask

    task automatic wait_done(input int d0, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (n_done != d0) begin
                ok = 1'b1;
                break;
            end
            step(1);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        step(2);
        tests_run++; if (bus.idle !== 1'b1) begin tests_failed++; $display("FAIL reset_idle: got %b want 1", bus.idle); end
        tests_run++; if (bus.timer_clear !== 1'b1) begin tests_failed++; $display("FAIL reset_timer_clear: got %b want 1", bus.timer_clear); end
        tests_run++; if ({bus.eop, bus.tx_transfer_active, bus.pts_load_enable, bus.tx_error, bus.packet_done} !== 5'b00000) begin
            tests_failed++; $display("FAIL reset_others: got %b want 00000", {bus.eop, bus.tx_transfer_active, bus.pts_load_enable, bus.tx_error, bus.packet_done});
        end
        rst = 1'b0;
        step(1);
    endtask

    task automatic test_ack;
        int d0 = n_done, l0 = ld_log.size(), b0 = n_bt, s0 = n_eop_str, gap = 1;
        bit ok;
        send(4'b0010);
        wait_done(d0, ok);
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL ack_timeout: packet_done not seen"); end
        tests_run++; if (log_sig(l0) !== 32'h2000_0001) begin tests_failed++; $display("FAIL ack_loads: got %h want 20000001", log_sig(l0)); end
        tests_run++; if (n_bt - b0 !== 2) begin tests_failed++; $display("FAIL ack_bytes: got %0d want 2", n_bt - b0); end
        tests_run++; if (n_eop_str - s0 !== 2) begin tests_failed++; $display("FAIL ack_eop_strobes: got %0d want 2", n_eop_str - s0); end
        tests_run++; if ({bus.idle, bus.tx_transfer_active, bus.timer_clear} !== 3'b100) begin
            tests_failed++; $display("FAIL ack_gap_state: got %b want 100", {bus.idle, bus.tx_transfer_active, bus.timer_clear});
        end
        while (bus.timer_clear !== 1'b1 && gap < 20) begin
            step(1);
            gap++;
        end
        tests_run++; if (gap !== GAP + 1) begin tests_failed++; $display("FAIL ack_gap_len: got %0d want %0d", gap - 1, GAP); end
        tests_run++; if (n_done - d0 !== 1) begin tests_failed++; $display("FAIL ack_done_count: got %0d want 1", n_done - d0); end
    endtask

    task automatic test_data0;
        int d0 = n_done, l0 = ld_log.size(), c0 = n_crcclr, e0 = n_err;
        bit ok;
        fifo_base = 3; pop_base = pop_cnt; hold_occ = 1'b0;
        send(4'b0011);
        wait_done(d0, ok);
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL data0_timeout: packet_done not seen"); end
        tests_run++; if (log_sig(l0) !== 32'h7012_2256) begin tests_failed++; $display("FAIL data0_loads: got %h want 70122256", log_sig(l0)); end
        tests_run++; if (pop_cnt - pop_base !== 3) begin tests_failed++; $display("FAIL data0_pops: got %0d want 3", pop_cnt - pop_base); end
        tests_run++; if (n_crcclr - c0 !== 1) begin tests_failed++; $display("FAIL data0_crc_clear: got %0d want 1", n_crcclr - c0); end
        tests_run++; if (n_err - e0 !== 0) begin tests_failed++; $display("FAIL data0_error: got %0d want 0", n_err - e0); end
    endtask

    task automatic test_token;
        int d0 = n_done, l0 = ld_log.size();
        bit ok;
        fifo_base = 5; pop_base = pop_cnt; hold_occ = 1'b0;
        send(4'b1001);
        wait_done(d0, ok);
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL token_timeout: packet_done not seen"); end
        tests_run++; if (log_sig(l0) !== 32'h4000_0134) begin tests_failed++; $display("FAIL token_loads: got %h want 40000134", log_sig(l0)); end
        tests_run++; if (pop_cnt - pop_base !== 0) begin tests_failed++; $display("FAIL token_pops: got %0d want 0", pop_cnt - pop_base); end
    endtask

    task automatic test_overflow;
        int d0 = n_done, l0 = ld_log.size(), e0 = n_err, s0 = n_eop_str;
        bit ok;
        fifo_base = 10; pop_base = pop_cnt; hold_occ = 1'b1;
        send(4'b0011);
        wait_done(d0, ok);
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL ovf_timeout: packet_done not seen"); end
        tests_run++; if (pop_cnt - pop_base !== MAXB) begin tests_failed++; $display("FAIL ovf_pops: got %0d want %0d", pop_cnt - pop_base, MAXB); end
        tests_run++; if (n_err - e0 !== 1) begin tests_failed++; $display("FAIL ovf_error_cycles: got %0d want 1", n_err - e0); end
        tests_run++; if (log_sig(l0) !== 32'h6001_2222) begin tests_failed++; $display("FAIL ovf_loads: got %h want 60012222", log_sig(l0)); end
        tests_run++; if (n_eop_str - s0 !== 2) begin tests_failed++; $display("FAIL ovf_eop_strobes: got %0d want 2", n_eop_str - s0); end
        hold_occ = 1'b0; fifo_base = 0; pop_base = pop_cnt;
    endtask

    task automatic test_zlp;
        int d0 = n_done, l0 = ld_log.size(), e0 = n_err;
        bit ok;
        fifo_base = 0; pop_base = pop_cnt;
        send(4'b1011);
`ifdef ZLP_EN
        wait_done(d0, ok);
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL zlp_timeout: packet_done not seen"); end
        tests_run++; if (log_sig(l0) !== 32'h4000_0156) begin tests_failed++; $display("FAIL zlp_loads: got %h want 40000156", log_sig(l0)); end
        tests_run++; if (n_err - e0 !== 0) begin tests_failed++; $display("FAIL zlp_error: got %0d want 0", n_err - e0); end
`else
        ok = 1'b1;
        step(4);
        tests_run++; if (log_sig(l0) !== 32'h0) begin tests_failed++; $display("FAIL zlp_loads: got %h want 00000000", log_sig(l0)); end
        tests_run++; if (n_err - e0 !== 1) begin tests_failed++; $display("FAIL zlp_error: got %0d want 1", n_err - e0); end
        tests_run++; if (n_done - d0 !== 0) begin tests_failed++; $display("FAIL zlp_done: got %0d want 0", n_done - d0); end
        tests_run++; if ({bus.idle, bus.timer_clear, ok} !== 3'b111) begin tests_failed++; $display("FAIL zlp_back_idle: got %b want 11", {bus.idle, bus.timer_clear}); end
`endif
    endtask

    task automatic test_bad_pid;
        int l0 = ld_log.size(), e0 = n_err;
        send(4'b0101);
        step(4);
        tests_run++; if (n_err - e0 !== 1) begin tests_failed++; $display("FAIL badpid_error: got %0d want 1", n_err - e0); end
        tests_run++; if (log_sig(l0) !== 32'h0) begin tests_failed++; $display("FAIL badpid_loads: got %h want 00000000", log_sig(l0)); end
    endtask

    task automatic test_back_to_back;
        int d0 = n_done;
        bit ok, bad = 1'b0;
        for (int c = 0; c < 50 && bus.timer_clear !== 1'b1; c++) step(1);
        bus.tx_packet = 4'b1010;
        step(1);
        wait_done(d0, ok);
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL b2b_timeout: first packet_done not seen"); end
        for (int k = 0; k < GAP; k++) begin
            if (bus.pts_load_enable !== 1'b0 || bus.idle !== 1'b1) bad = 1'b1;
            step(1);
        end
        tests_run++; if (bad !== 1'b0) begin tests_failed++; $display("FAIL b2b_gap_ignores_req: got load during gap, want none"); end
        tests_run++; if (bus.timer_clear !== 1'b1) begin tests_failed++; $display("FAIL b2b_idle_after_gap: got %b want 1", bus.timer_clear); end
        step(1);
        tests_run++; if ({bus.pts_load_enable, bus.load_sel} !== 4'b1000) begin
            tests_failed++; $display("FAIL b2b_restart: got %b want 1000", {bus.pts_load_enable, bus.load_sel});
        end
        bus.tx_packet = 4'd0;
        wait_done(d0 + 1, ok);
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL b2b_timeout2: second packet_done not seen"); end
    endtask

    task automatic test_reset_mid;
        int l0 = ld_log.size(), d0;
        bit ok, found = 1'b0;
        fifo_base = 3; pop_base = pop_cnt;
        send(4'b0011);
        for (int c = 0; c < 100; c++) begin
            if (ld_log.size() >= l0 + 3 && bus.pts_shift_enable === 1'b1) begin
                found = 1'b1;
                break;
            end
            step(1);
        end
        tests_run++; if (!found) begin tests_failed++; $display("FAIL rstmid_reach_data: DATA shift not reached"); end
        rst = 1'b1;
        step(1);
        tests_run++; if ({bus.idle, bus.timer_clear, bus.eop, bus.tx_transfer_active} !== 4'b1100) begin
            tests_failed++; $display("FAIL rstmid_state: got %b want 1100", {bus.idle, bus.timer_clear, bus.eop, bus.tx_transfer_active});
        end
        rst = 1'b0;
        fifo_base = 0; pop_base = pop_cnt;
        step(1);
        d0 = n_done; l0 = ld_log.size();
        send(4'b0010);
        wait_done(d0, ok);
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL rstmid_timeout: packet after reset not done"); end
        tests_run++; if (log_sig(l0) !== 32'h2000_0001) begin tests_failed++; $display("FAIL rstmid_loads: got %h want 20000001", log_sig(l0)); end
    endtask

    initial begin
        bus.tx_packet = 4'd0;
        test_reset();
        test_ack();
        test_data0();
        test_token();
        test_overflow();
        test_zlp();
        test_bad_pid();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
